// File: rtl/timing_pkg.sv
// Shared types and constants for the per-bank DRAM timing tracker.
// Holds the bank state codes, command bit positions, default delays and decode helpers.
package timing_pkg;

    typedef enum logic [4:0] {
        S_IDLE          = 5'h00,
        S_ACTIVATING    = 5'h01,
        S_ACT_PD        = 5'h02,
        S_BANK_ACTIVE   = 5'h03,
        S_IDLE_PD       = 5'h07,
        S_PRECHARGING   = 5'h0a,
        S_READING       = 5'h0b,
        S_READING_AP    = 5'h0c,
        S_REFRESHING    = 5'h0d,
        S_SELF_REFRESH  = 5'h10,
        S_WRITING       = 5'h12,
        S_WRITING_AP    = 5'h13,
        S_ROWCLONE      = 5'h14
    } bank_state_e;

    // What a single bank is told to do this cycle, after decode and broadcast.
    typedef enum logic [3:0] {
        OP_NONE, OP_ACT, OP_CLONE, OP_REF, OP_PD, OP_PDX,
        OP_SRF, OP_RD, OP_RDA, OP_WR, OP_WRA, OP_PR
    } bank_op_e;

    localparam int NUM_CMDS = 19;
    localparam int CMD_ACT  = 18;
    localparam int CMD_BST  = 17;
    localparam int CMD_CFG  = 16;
    localparam int CMD_CKEH = 15;
    localparam int CMD_CKEL = 14;
    localparam int CMD_DPD  = 13;
    localparam int CMD_DPDX = 12;
    localparam int CMD_MRR  = 11;
    localparam int CMD_MRW  = 10;
    localparam int CMD_PD   = 9;
    localparam int CMD_PDX  = 8;
    localparam int CMD_PR   = 7;
    localparam int CMD_PRA  = 6;
    localparam int CMD_RD   = 5;
    localparam int CMD_RDA  = 4;
    localparam int CMD_REF  = 3;
    localparam int CMD_SRF  = 2;
    localparam int CMD_WR   = 1;
    localparam int CMD_WRA  = 0;

    localparam int DEF_BL    = 8;
    localparam int DEF_T_CL  = 17;
    localparam int DEF_T_RCD = 17;
    localparam int DEF_T_WR  = 14;
    localparam int DEF_T_RP  = 17;
    localparam int DEF_T_RFC = 34;

    // Longest dwell of any timed state, used to size the per-bank counter.
    function automatic int max_delay(input int bl, input int t_rcd, input int t_wr,
                                     input int t_rp, input int t_rfc);
        int m;
        m = t_rcd;
        if (t_wr + 1 > m) m = t_wr + 1;
        if (bl + 1 > m)   m = bl + 1;
        if (t_rp > m)     m = t_rp;
        if (t_rfc > m)    m = t_rfc;
        return m;
    endfunction

    // Index of the highest set command bit, or -1 when no bit is set.
    function automatic int top_cmd(input logic [NUM_CMDS-1:0] c);
        int idx;
        idx = -1;
        for (int i = 0; i < NUM_CMDS; i++) begin
            if (c[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic bank_op_e cmd_to_op(input int c);
        bank_op_e op;
        case (c)
            CMD_ACT: op = OP_ACT;
            CMD_REF: op = OP_REF;
            CMD_PD:  op = OP_PD;
            CMD_PDX: op = OP_PDX;
            CMD_SRF: op = OP_SRF;
            CMD_RD:  op = OP_RD;
            CMD_RDA: op = OP_RDA;
            CMD_WR:  op = OP_WR;
            CMD_WRA: op = OP_WRA;
            CMD_PR:  op = OP_PR;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/bank_timing_fsm.sv
// One DRAM bank: state register plus dwell down-counter.
// Timed states load the counter on entry and leave when it reaches zero.
module bank_timing_fsm
    import timing_pkg::*;
#(
    parameter int BL    = DEF_BL,
    parameter int T_RCD = DEF_T_RCD,
    parameter int T_WR  = DEF_T_WR,
    parameter int T_RP  = DEF_T_RP,
    parameter int T_RFC = DEF_T_RFC,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  bank_op_e    op,
    output bank_state_e state
);

    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_WR);
    localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(BL);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);

    bank_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired;

    assign expired = (cnt_q == '0);
    assign state   = state_q;

    // NOTE: state registers use non-blocking assignments so every bank samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first, so every path assigns state_d/cnt_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                case (op)
                    OP_ACT: begin state_d = S_ACTIVATING;   cnt_d = LD_RCD; end
                    OP_REF: begin state_d = S_REFRESHING;   cnt_d = LD_RFC; end
                    OP_PD:  state_d = S_IDLE_PD;
                    OP_SRF: state_d = S_SELF_REFRESH;
                    default: ;
                endcase
            end
            S_IDLE_PD, S_SELF_REFRESH: if (op == OP_PDX) state_d = S_IDLE;
            S_ACT_PD:                  if (op == OP_PDX) state_d = S_BANK_ACTIVE;
            S_BANK_ACTIVE, S_READING, S_WRITING: begin
                // A burst in flight runs down unless a new column/precharge command pre-empts it.
                if (state_q != S_BANK_ACTIVE) begin
                    if (expired) state_d = S_BANK_ACTIVE;
                    else         cnt_d   = cnt_q - CNT_W'(1);
                end
                case (op)
                    OP_RD:  begin state_d = S_READING;     cnt_d = LD_RD; end
                    OP_RDA: begin state_d = S_READING_AP;  cnt_d = LD_RD; end
                    OP_WR:  begin state_d = S_WRITING;     cnt_d = LD_WR; end
                    OP_WRA: begin state_d = S_WRITING_AP;  cnt_d = LD_WR; end
                    OP_PR:  begin state_d = S_PRECHARGING; cnt_d = LD_RP; end
                    OP_PD:    if (state_q == S_BANK_ACTIVE) state_d = S_ACT_PD;
                    OP_CLONE: if (state_q == S_BANK_ACTIVE) begin
                        state_d = S_ROWCLONE;
                        cnt_d   = LD_RCD;
                    end
                    default: ;
                endcase
            end
            S_ACTIVATING, S_ROWCLONE: begin
                if (expired) state_d = S_BANK_ACTIVE;
                else         cnt_d   = cnt_q - CNT_W'(1);
            end
            S_READING_AP, S_WRITING_AP: begin
                if (expired) begin
                    state_d = S_PRECHARGING;
                    cnt_d   = LD_RP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PRECHARGING, S_REFRESHING: begin
                if (expired) state_d = S_IDLE;
                else         cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/timing_fsm.sv
// Per-bank DRAM timing tracker: command priority decode, RowClone/PRA broadcast,
// and one bank_timing_fsm per bank group x bank, exported as BankFSM.
module timing_fsm
    import timing_pkg::*;
#(
    parameter int BGWIDTH    = 2,
    parameter int BANKGROUPS = 2 ** BGWIDTH,
    parameter int BAWIDTH    = 2,
    parameter int BL         = DEF_BL,
    parameter int T_CL       = DEF_T_CL,
    parameter int T_RCD      = DEF_T_RCD,
    parameter int T_WR       = DEF_T_WR,
    parameter int T_RP       = DEF_T_RP,
    parameter int T_RFC      = DEF_T_RFC,
    localparam int BANKSPERGROUP = 2 ** BAWIDTH
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic [BGWIDTH-1:0]                             bg,
    input  logic [BAWIDTH-1:0]                             ba,
    input  logic [NUM_CMDS-1:0]                            commands,
    output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][4:0]  BankFSM
);

    localparam int CNT_W = $clog2(max_delay(BL, T_RCD, T_WR, T_RP, T_RFC) + 2);

    if (BANKGROUPS != 2 ** BGWIDTH || T_CL < 1 || T_RCD < 1 || T_WR < 0 ||
        T_RP < 1 || T_RFC < 1 || BL < 0) begin : g_param_err
        $error("timing_fsm: inconsistent geometry or timing parameters");
    end

    bank_state_e bank_state [BANKGROUPS][BANKSPERGROUP];
    bank_op_e    bank_op    [BANKGROUPS][BANKSPERGROUP];
    int          win;
    logic        clone_hit;

    assign win = top_cmd(commands);

    // ACT into a group that already has an open row becomes an in-DRAM copy.
    always_comb begin
        clone_hit = 1'b0;
        for (int b = 0; b < BANKSPERGROUP; b++) begin
            if (bank_state[bg][b] == S_BANK_ACTIVE) clone_hit = 1'b1;
        end
    end

    always_comb begin
        for (int g = 0; g < BANKGROUPS; g++) begin
            for (int b = 0; b < BANKSPERGROUP; b++) begin
                bank_op[g][b] = OP_NONE;
                if (win == CMD_PRA) begin
                    bank_op[g][b] = OP_PR;
                end else if (win == CMD_ACT && clone_hit) begin
                    if (BGWIDTH'(g) == bg && bank_state[g][b] == S_BANK_ACTIVE)
                        bank_op[g][b] = OP_CLONE;
                end else if (BGWIDTH'(g) == bg && BAWIDTH'(b) == ba) begin
                    bank_op[g][b] = cmd_to_op(win);
                end
            end
        end
    end

    for (genvar g = 0; g < BANKGROUPS; g++) begin : g_grp
        for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
            bank_timing_fsm #(
                .BL    (BL),
                .T_RCD (T_RCD),
                .T_WR  (T_WR),
                .T_RP  (T_RP),
                .T_RFC (T_RFC),
                .CNT_W (CNT_W)
            ) u_bank (
                .clk     (clk),
                .reset_n (reset_n),
                .op      (bank_op[g][b]),
                .state   (bank_state[g][b])
            );
            assign BankFSM[g][b] = bank_state[g][b];
        end
    end

endmodule

// File: tb/tb_timing_fsm.sv
// Self-checking bench for timing_fsm: directed scenarios with literal expectations,
// then randomized commands checked every cycle against a timestamp-based bank model.
module tb_timing_fsm;

    localparam int NG = 4, NB = 4, VW = NG * NB * 5;
    localparam int BL = 8, T_CL = 17, T_RCD = 17, T_WR = 14, T_RP = 17, T_RFC = 34;

    localparam logic [4:0] ST_IDLE = 5'h00, ST_ACTIVATING = 5'h01, ST_ACT_PD = 5'h02,
                           ST_ACTIVE = 5'h03, ST_IDLE_PD = 5'h07, ST_PRECHG = 5'h0a,
                           ST_READING = 5'h0b, ST_READING_AP = 5'h0c, ST_REFRESH = 5'h0d,
                           ST_SELF_REF = 5'h10, ST_WRITING = 5'h12, ST_WRITING_AP = 5'h13,
                           ST_ROWCLONE = 5'h14;

    localparam int B_ACT = 18, B_BST = 17, B_MRR = 11, B_PD = 9, B_PDX = 8, B_PR = 7,
                   B_PRA = 6, B_RD = 5, B_RDA = 4, B_REF = 3, B_SRF = 2, B_WR = 1, B_WRA = 0;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [1:0]                 bg, ba;
    logic [18:0]                commands;
    logic [NG-1:0][NB-1:0][4:0] BankFSM;

    timing_fsm #(
        .BGWIDTH(2), .BANKGROUPS(NG), .BAWIDTH(2), .BL(BL), .T_CL(T_CL),
        .T_RCD(T_RCD), .T_WR(T_WR), .T_RP(T_RP), .T_RFC(T_RFC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bg(bg), .ba(ba),
        .commands(commands), .BankFSM(BankFSM)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Each bank holds a state and the edge number at which its dwell ends.
    logic [4:0] m_state [NG][NB];
    int         m_until [NG][NB];
    int         cyc = 0;
    int         m_win, m_tgt;
    logic       m_clone;
    logic [4:0] m_s;

    function automatic int dwell(input logic [4:0] s);
        case (s)
            ST_ACTIVATING, ST_ROWCLONE:   return T_RCD;
            ST_WRITING, ST_WRITING_AP:    return T_WR + 1;
            ST_READING, ST_READING_AP:    return BL + 1;
            ST_PRECHG:                    return T_RP;
            ST_REFRESH:                   return T_RFC;
            default:                      return 0;
        endcase
    endfunction

    function automatic logic [4:0] after(input logic [4:0] s);
        case (s)
            ST_READING_AP, ST_WRITING_AP: return ST_PRECHG;
            ST_PRECHG, ST_REFRESH:        return ST_IDLE;
            default:                      return ST_ACTIVE;
        endcase
    endfunction

    // New state for a command aimed at this bank, or -1 when it has no effect.
    function automatic int cmd_target(input logic [4:0] s, input int c);
        int r;
        r = -1;
        if (s == ST_IDLE) begin
            if (c == B_ACT) r = ST_ACTIVATING;
            if (c == B_REF) r = ST_REFRESH;
            if (c == B_PD)  r = ST_IDLE_PD;
            if (c == B_SRF) r = ST_SELF_REF;
        end else if (s == ST_IDLE_PD || s == ST_SELF_REF) begin
            if (c == B_PDX) r = ST_IDLE;
        end else if (s == ST_ACT_PD) begin
            if (c == B_PDX) r = ST_ACTIVE;
        end else if (s == ST_ACTIVE || s == ST_READING || s == ST_WRITING) begin
            if (c == B_RD)  r = ST_READING;
            if (c == B_RDA) r = ST_READING_AP;
            if (c == B_WR)  r = ST_WRITING;
            if (c == B_WRA) r = ST_WRITING_AP;
            if (c == B_PR)  r = ST_PRECHG;
            if (c == B_PD && s == ST_ACTIVE) r = ST_ACT_PD;
        end
        return r;
    endfunction

    task automatic m_enter(input int g, input int b, input logic [4:0] ns);
        m_state[g][b] = ns;
        m_until[g][b] = cyc + dwell(ns);
    endtask

    initial begin
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++) begin
                m_state[g][b] = ST_IDLE;
                m_until[g][b] = 0;
            end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < NG; g++)
                for (int b = 0; b < NB; b++) begin
                    m_state[g][b] = ST_IDLE;
                    m_until[g][b] = 0;
                end
        end else begin
            cyc++;
            m_win = -1;
            for (int i = 0; i < 19; i++) if (commands[i]) m_win = i;
            m_clone = 1'b0;
            if (m_win == B_ACT)
                for (int b = 0; b < NB; b++) if (m_state[bg][b] == ST_ACTIVE) m_clone = 1'b1;
            for (int g = 0; g < NG; g++) begin
                for (int b = 0; b < NB; b++) begin
                    m_s   = m_state[g][b];
                    m_tgt = -1;
                    if (m_win == B_PRA) begin
                        if (m_s == ST_ACTIVE || m_s == ST_READING || m_s == ST_WRITING) m_tgt = ST_PRECHG;
                    end else if (m_clone) begin
                        if (g == int'(bg) && m_s == ST_ACTIVE) m_tgt = ST_ROWCLONE;
                    end else if (m_win >= 0 && g == int'(bg) && b == int'(ba)) begin
                        m_tgt = cmd_target(m_s, m_win);
                    end
                    if (m_tgt >= 0)                              m_enter(g, b, 5'(m_tgt));
                    else if (dwell(m_s) > 0 && cyc == m_until[g][b]) m_enter(g, b, after(m_s));
                end
            end
        end
    end

    logic [NG-1:0][NB-1:0][4:0] expv;
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int g = 0; g < NG; g++)
                for (int b = 0; b < NB; b++) expv[g][b] = m_state[g][b];
            check("model_cycle", BankFSM, expv);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue2(input int bit_a, input int bit_b, input int g, input int b);
        commands        = '0;
        commands[bit_a] = 1'b1;
        commands[bit_b] = 1'b1;
        bg = 2'(g);
        ba = 2'(b);
        @(negedge clk);
        commands = '0;
    endtask

    task automatic issue(input int bit_i, input int g, input int b);
        issue2(bit_i, bit_i, g, b);
    endtask

    task automatic chk_bank(input string name, input int g, input int b, input logic [4:0] e);
        check(name, BankFSM[g][b], e);
        check({name, "_ref"}, m_state[g][b], e);
    endtask

    int pick_list [15] = '{B_ACT, B_ACT, B_ACT, B_RD, B_RDA, B_WR, B_WRA, B_PR,
                           B_PRA, B_REF, B_PD, B_PDX, B_SRF, B_BST, B_MRR};

    initial begin
        reset_n  = 1'b0;
        commands = '0;
        bg = '0;
        ba = '0;
        tick(3);
        check("reset_state", BankFSM, '0);
        reset_n = 1'b1;
        tick(3);
        check("idle_after_release", BankFSM, '0);
        cmp_en = 1'b1;

        // ACT / WR / RD / WR / PR on bank[0][1]
        issue(B_ACT, 0, 1);  chk_bank("act_first", 0, 1, ST_ACTIVATING);
        tick(T_RCD - 1);     chk_bank("act_last", 0, 1, ST_ACTIVATING);
        tick(1);             chk_bank("act_done", 0, 1, ST_ACTIVE);
        issue(B_WR, 0, 1);   chk_bank("wr_first", 0, 1, ST_WRITING);
        tick(T_WR);          chk_bank("wr_last", 0, 1, ST_WRITING);
        tick(1);             chk_bank("wr_done", 0, 1, ST_ACTIVE);
        issue(B_RD, 0, 1);   chk_bank("rd_first", 0, 1, ST_READING);
        tick(1);
        issue(B_WR, 0, 1);   chk_bank("wr_over_rd", 0, 1, ST_WRITING);
        issue(B_PR, 0, 1);   chk_bank("pr_over_wr", 0, 1, ST_PRECHG);
        tick(T_RP - 1);      chk_bank("pr_last", 0, 1, ST_PRECHG);
        tick(1);             check("pr_done_all_idle", BankFSM, '0);

        // Refresh from Idle
        issue(B_REF, 0, 1);  chk_bank("ref_first", 0, 1, ST_REFRESH);
        tick(T_RFC - 1);     chk_bank("ref_last", 0, 1, ST_REFRESH);
        tick(1);             chk_bank("ref_done", 0, 1, ST_IDLE);

        // Write with auto-precharge
        issue(B_ACT, 0, 1);  tick(T_RCD);
        issue(B_WRA, 0, 1);  chk_bank("wra_first", 0, 1, ST_WRITING_AP);
        tick(T_WR);          chk_bank("wra_last", 0, 1, ST_WRITING_AP);
        tick(1);             chk_bank("wra_to_pr", 0, 1, ST_PRECHG);
        tick(T_RP - 1);      chk_bank("wra_pr_last", 0, 1, ST_PRECHG);
        tick(1);             chk_bank("wra_idle", 0, 1, ST_IDLE);

        // RowClone, then read with auto-precharge
        issue(B_ACT, 0, 1);  tick(T_RCD);
        issue(B_ACT, 0, 0);  chk_bank("clone_first", 0, 1, ST_ROWCLONE);
                             chk_bank("clone_target_idle", 0, 0, ST_IDLE);
        tick(T_RCD - 1);     chk_bank("clone_last", 0, 1, ST_ROWCLONE);
        tick(1);             chk_bank("clone_done", 0, 1, ST_ACTIVE);
                             chk_bank("clone_ba_ignored", 0, 0, ST_IDLE);
        issue(B_RDA, 0, 1);  chk_bank("rda_first", 0, 1, ST_READING_AP);
        tick(BL);            chk_bank("rda_last", 0, 1, ST_READING_AP);
        tick(1);             chk_bank("rda_to_pr", 0, 1, ST_PRECHG);
        tick(T_RP);          chk_bank("rda_idle", 0, 1, ST_IDLE);

        // Priority among simultaneous bits, power-down, and PRA broadcast
        issue(B_ACT, 0, 1);  tick(T_RCD);
        issue2(B_BST, B_RD, 0, 1); chk_bank("bst_beats_rd", 0, 1, ST_ACTIVE);
        issue2(B_PD, B_RD, 0, 1);  chk_bank("pd_beats_rd", 0, 1, ST_ACT_PD);
        issue(B_PDX, 0, 1);  chk_bank("pdx_active", 0, 1, ST_ACTIVE);
        issue(B_ACT, 1, 2);  chk_bank("act_other_group", 1, 2, ST_ACTIVATING);
        tick(T_RCD);
        issue(B_PRA, 3, 3);  chk_bank("pra_bank01", 0, 1, ST_PRECHG);
                             chk_bank("pra_bank12", 1, 2, ST_PRECHG);
        tick(T_RP);          check("pra_all_idle", BankFSM, '0);

        // Asynchronous reset in the middle of a refresh
        issue(B_REF, 2, 3);  tick(5);
        chk_bank("ref_mid", 2, 3, ST_REFRESH);
        #2 reset_n = 1'b0;
        #1 check("async_reset_immediate", BankFSM, '0);
        @(negedge clk) reset_n = 1'b1;
        tick(2);             check("idle_after_reset", BankFSM, '0);

        // Randomized traffic checked by the per-cycle compare process
        for (int c = 0; c < 3000; c++) begin
            int r;
            commands = '0;
            r = $urandom_range(0, 99);
            if (r >= 15) commands[pick_list[$urandom_range(0, 14)]] = 1'b1;
            if (r >= 90) commands[$urandom_range(0, 18)] = 1'b1;
            bg = 2'($urandom_range(0, 3));
            ba = 2'($urandom_range(0, 3));
            if (c == 1500) begin
                #2 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            @(negedge clk);
        end
        commands = '0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
